// File: rtl/adder_pkg.sv
// Shared definitions for the chunked adder.
//   adder_state_t : control FSM encoding (IDLE, BUSY, DONE).
//   calc_nchunk   : number of chunks per operation; returns 0 when WIDTH is
//                   not a positive multiple of CHUNK so the instantiating
//                   module can reject the configuration at elaboration.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } adder_state_t;

    function automatic int calc_nchunk(input int width, input int chunk);
        if (chunk < 1 || width < 1) begin
            return 0;
        end
        if ((width % chunk) != 0) begin
            return 0;
        end
        return width / chunk;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder built from fulladder cells.
// Ports:
//   a, b  : CHUNK-bit addends
//   cin   : carry into bit 0
//   s     : CHUNK-bit sum
//   cout  : carry out of the top bit
//   c_msb : carry into the top bit (needed for signed overflow)
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    // Each bit keeps its own carry nets so the chain is a plain sequence of
    // separate wires rather than one vector that feeds back into itself.
    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        logic ci;
        logic co;

        if (i == 0) begin : g_first
            assign ci = cin;
        end else begin : g_next
            assign ci = g_bit[i-1].co;
        end

        fulladder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (ci),
            .s    (s[i]),
            .cout (co)
        );
    end

    assign cout  = g_bit[CHUNK-1].co;
    assign c_msb = g_bit[CHUNK-1].ci;

endmodule

// File: rtl/fulladder.sv
// Single-bit full adder, the leaf cell of the chunk ripple.
// Ports:
//   a, b, cin : addend bits and incoming carry
//   s         : sum bit
//   cout      : outgoing carry
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle adder: computes a + b + cin over WIDTH bits, CHUNK bits per
// clock, with the inter-chunk carry held in a register. Operands enter and
// the result leaves through valid/ready handshakes.
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous, active-high
//   in_valid  : operand set offered
//   in_ready  : block idle and able to accept operands
//   a, b      : WIDTH-bit operands
//   cin       : carry-in
//   out_valid : result available (registered)
//   out_ready : consumer takes the result
//   s         : registered sum, a + b + cin mod 2^WIDTH
//   cout      : registered unsigned carry-out
//   ovf       : registered signed overflow (carry into MSB ^ carry out of MSB)
module chunked_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    if (NCHUNK == 0) begin : g_param_check
        $error("chunked_adder: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)",
               WIDTH, CHUNK);
    end

    adder_state_t     state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_acc;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic [IDXW-1:0]  idx;
    logic [CHUNK-1:0] chunk_s;
    logic             chunk_cout;
    logic             chunk_cmsb;
    logic             accept;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a     (a_sh[CHUNK-1:0]),
        .b     (b_sh[CHUNK-1:0]),
        .cin   (carry),
        .s     (chunk_s),
        .cout  (chunk_cout),
        .c_msb (chunk_cmsb)
    );

    // The new chunk enters at the top of the accumulator; after NCHUNK shifts
    // the first (least significant) chunk has reached bit 0. Written with
    // shifts so CHUNK == WIDTH needs no special-case slicing.
    assign sum_next = (sum_acc >> CHUNK) | (WIDTH'(chunk_s) << (WIDTH - CHUNK));

    // NOTE: operand and accumulator registers are not reset; they are always
    // loaded on accept before any BUSY cycle reads them, and the control
    // registers below decide whether their contents ever become visible.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh    <= a;
            b_sh    <= b;
            sum_acc <= '0;
        end else if (state == BUSY) begin
            a_sh    <= a_sh >> CHUNK;
            b_sh    <= b_sh >> CHUNK;
            sum_acc <= sum_next;
        end
    end

    // NOTE: every register here is assigned with <= so all of them update
    // from the same pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            carry     <= 1'b0;
            idx       <= '0;
            out_valid <= 1'b0;
            s         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        carry <= cin;
                        idx   <= '0;
                        state <= BUSY;
                    end
                end

                BUSY: begin
                    carry <= chunk_cout;
                    idx   <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        // Final chunk: its carries are those of the full MSB.
                        s         <= sum_next;
                        cout      <= chunk_cout;
                        ovf       <= chunk_cmsb ^ chunk_cout;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_adder.sv
// Directed and randomised self-checking bench for chunked_adder.
// Three instances share clock and reset: 8/2 (directed tests), 8/8 and 16/1
// (random operands against an arithmetic model, latency and issue interval).
// Inputs are driven and outputs sampled on the falling edge.
module tb_chunked_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared   = 0;
    int mismatched = 0;

    logic reset;

    // WIDTH=8, CHUNK=2
    logic       m_in_valid, m_in_ready, m_out_valid, m_out_ready;
    logic [7:0] m_a, m_b, m_s;
    logic       m_cin, m_cout, m_ovf;

    // WIDTH=8, CHUNK=8
    logic       p_in_valid, p_in_ready, p_out_valid, p_out_ready;
    logic [7:0] p_a, p_b, p_s;
    logic       p_cin, p_cout, p_ovf;

    // WIDTH=16, CHUNK=1
    logic        q_in_valid, q_in_ready, q_out_valid, q_out_ready;
    logic [15:0] q_a, q_b, q_s;
    logic        q_cin, q_cout, q_ovf;

    chunked_adder #(.WIDTH(8), .CHUNK(2)) dut (
        .clk(clk), .reset(reset), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .a(m_a), .b(m_b), .cin(m_cin), .out_valid(m_out_valid),
        .out_ready(m_out_ready), .s(m_s), .cout(m_cout), .ovf(m_ovf)
    );

    chunked_adder #(.WIDTH(8), .CHUNK(8)) dut_w8c8 (
        .clk(clk), .reset(reset), .in_valid(p_in_valid), .in_ready(p_in_ready),
        .a(p_a), .b(p_b), .cin(p_cin), .out_valid(p_out_valid),
        .out_ready(p_out_ready), .s(p_s), .cout(p_cout), .ovf(p_ovf)
    );

    chunked_adder #(.WIDTH(16), .CHUNK(1)) dut_w16c1 (
        .clk(clk), .reset(reset), .in_valid(q_in_valid), .in_ready(q_in_ready),
        .a(q_a), .b(q_b), .cin(q_cin), .out_valid(q_out_valid),
        .out_ready(q_out_ready), .s(q_s), .cout(q_cout), .ovf(q_ovf)
    );

    // One full operation on the 8/2 instance: accept, latency, result, consume.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                         input logic [7:0] es, input logic ec, input logic eo,
                         input string nm);
        int lat;
        compared++;
        if (m_in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL %s ready_before: in_ready=%b want 1", nm, m_in_ready);
        end
        m_a = ta; m_b = tb_v; m_cin = tc; m_in_valid = 1'b1;
        @(negedge clk);
        m_in_valid = 1'b0;
        lat = 0;
        while (m_out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        compared++;
        if (lat !== 4) begin
            mismatched++;
            $display("FAIL %s latency: got %0d want 4", nm, lat);
        end
        compared++;
        if ({m_s, m_cout, m_ovf} !== {es, ec, eo}) begin
            mismatched++;
            $display("FAIL %s result: got s=%h cout=%b ovf=%b want s=%h cout=%b ovf=%b",
                     nm, m_s, m_cout, m_ovf, es, ec, eo);
        end
        m_out_ready = 1'b1;
        @(negedge clk);
        m_out_ready = 1'b0;
        compared++;
        if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL %s handshake: out_valid=%b in_ready=%b want 0/1",
                     nm, m_out_valid, m_in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        compared++;
        if ({m_s, m_cout, m_ovf} !== {8'h00, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_outputs: got s=%h cout=%b ovf=%b want 00/0/0", m_s, m_cout, m_ovf);
        end
        compared++;
        if (m_out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_out_valid: got %b want 0", m_out_valid);
        end
        compared++;
        if (m_in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_in_ready: got %b want 1", m_in_ready);
        end
        compared++;
        if (p_in_ready !== 1'b1 || q_in_ready !== 1'b1 || p_out_valid !== 1'b0 || q_out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_other_instances: in_ready=%b%b out_valid=%b%b want 11/00",
                     p_in_ready, q_in_ready, p_out_valid, q_out_valid);
        end
    endtask

    task automatic test_basic();
        do_op(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, "basic_3c_05");
    endtask

    task automatic test_carry_overflow();
        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "ripple_ff_01");
        do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "ovf_7f_01");
        do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "ovf_80_80");
    endtask

    task automatic test_backpressure();
        int lat;
        m_a = 8'h55; m_b = 8'hAA; m_cin = 1'b1; m_in_valid = 1'b1;
        @(negedge clk);
        m_in_valid = 1'b0;
        lat = 0;
        while (m_out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        compared++;
        if ({m_out_valid, m_s, m_cout, m_ovf} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL bp_result: got v=%b s=%h cout=%b ovf=%b want 1/00/1/0",
                     m_out_valid, m_s, m_cout, m_ovf);
        end
        // New operands offered while the result is still pending.
        m_a = 8'h01; m_b = 8'h02; m_cin = 1'b0; m_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            compared++;
            if ({m_in_ready, m_out_valid, m_s, m_cout, m_ovf} !== {1'b0, 1'b1, 8'h00, 1'b1, 1'b0}) begin
                mismatched++;
                $display("FAIL bp_hold cycle %0d: got rdy=%b v=%b s=%h cout=%b ovf=%b want 0/1/00/1/0",
                         i, m_in_ready, m_out_valid, m_s, m_cout, m_ovf);
            end
        end
        m_out_ready = 1'b1;
        @(negedge clk);
        m_out_ready = 1'b0;
        m_in_valid  = 1'b0;
        compared++;
        if ({m_in_ready, m_out_valid, m_s, m_cout, m_ovf} !== {1'b1, 1'b0, 8'h00, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL bp_release: got rdy=%b v=%b s=%h cout=%b ovf=%b want 1/0/00/1/0",
                     m_in_ready, m_out_valid, m_s, m_cout, m_ovf);
        end
        do_op(8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1, "bp_next_op");
    endtask

    task automatic test_reset_mid_op();
        logic seen_valid;
        m_a = 8'hF0; m_b = 8'h0F; m_cin = 1'b1; m_in_valid = 1'b1;
        @(negedge clk);            // accepted; first BUSY cycle
        m_in_valid = 1'b0;
        @(negedge clk);            // second BUSY cycle
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        compared++;
        if ({m_in_ready, m_out_valid, m_s, m_cout, m_ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL midreset_state: got rdy=%b v=%b s=%h cout=%b ovf=%b want 1/0/00/0/0",
                     m_in_ready, m_out_valid, m_s, m_cout, m_ovf);
        end
        seen_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (m_out_valid !== 1'b0) seen_valid = 1'b1;
        end
        compared++;
        if (seen_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_no_valid: got out_valid pulse=%b want 0", seen_valid);
        end
        do_op(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, "after_midreset");
    endtask

    task automatic test_random_w8c8();
        logic [7:0] ra, rb, es;
        logic       rc, ec, eo;
        logic [8:0] full;
        int lat, guard, t_acc, t_prev;
        t_prev = 0;
        ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
        p_a = ra; p_b = rb; p_cin = rc;
        p_out_ready = 1'b1; p_in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            guard = 0;
            while (p_in_ready !== 1'b1 && guard < 40) begin
                @(negedge clk);
                guard++;
            end
            full = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            es = full[7:0];
            ec = full[8];
            eo = (ra[7] == rb[7]) && (es[7] != ra[7]);
            @(negedge clk);
            t_acc = cyc;
            if (i > 0) begin
                compared++;
                if (t_acc - t_prev !== 3) begin
                    mismatched++;
                    $display("FAIL w8c8 interval op %0d: got %0d want 3", i, t_acc - t_prev);
                end
            end
            t_prev = t_acc;
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            p_a = ra; p_b = rb; p_cin = rc;
            lat = 0;
            while (p_out_valid !== 1'b1 && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            compared++;
            if (lat !== 1) begin
                mismatched++;
                $display("FAIL w8c8 latency op %0d: got %0d want 1", i, lat);
            end
            compared++;
            if ({p_s, p_cout, p_ovf} !== {es, ec, eo}) begin
                mismatched++;
                $display("FAIL w8c8 result op %0d: got s=%h cout=%b ovf=%b want s=%h cout=%b ovf=%b",
                         i, p_s, p_cout, p_ovf, es, ec, eo);
            end
        end
        p_in_valid = 1'b0;
        @(negedge clk);
        p_out_ready = 1'b0;
    endtask

    task automatic test_random_w16c1();
        logic [15:0] ra, rb, es;
        logic        rc, ec, eo;
        logic [16:0] full;
        int lat, guard, t_acc, t_prev;
        t_prev = 0;
        ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
        q_a = ra; q_b = rb; q_cin = rc;
        q_out_ready = 1'b1; q_in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            guard = 0;
            while (q_in_ready !== 1'b1 && guard < 60) begin
                @(negedge clk);
                guard++;
            end
            full = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
            es = full[15:0];
            ec = full[16];
            eo = (ra[15] == rb[15]) && (es[15] != ra[15]);
            @(negedge clk);
            t_acc = cyc;
            if (i > 0) begin
                compared++;
                if (t_acc - t_prev !== 18) begin
                    mismatched++;
                    $display("FAIL w16c1 interval op %0d: got %0d want 18", i, t_acc - t_prev);
                end
            end
            t_prev = t_acc;
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            q_a = ra; q_b = rb; q_cin = rc;
            lat = 0;
            while (q_out_valid !== 1'b1 && lat < 60) begin
                @(negedge clk);
                lat++;
            end
            compared++;
            if (lat !== 16) begin
                mismatched++;
                $display("FAIL w16c1 latency op %0d: got %0d want 16", i, lat);
            end
            compared++;
            if ({q_s, q_cout, q_ovf} !== {es, ec, eo}) begin
                mismatched++;
                $display("FAIL w16c1 result op %0d: got s=%h cout=%b ovf=%b want s=%h cout=%b ovf=%b",
                         i, q_s, q_cout, q_ovf, es, ec, eo);
            end
        end
        q_in_valid = 1'b0;
        @(negedge clk);
        q_out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        m_in_valid = 1'b0; m_out_ready = 1'b0; m_a = '0; m_b = '0; m_cin = 1'b0;
        p_in_valid = 1'b0; p_out_ready = 1'b0; p_a = '0; p_b = '0; p_cin = 1'b0;
        q_in_valid = 1'b0; q_out_ready = 1'b0; q_a = '0; q_b = '0; q_cin = 1'b0;

        test_reset();
        test_basic();
        test_carry_overflow();
        test_backpressure();
        test_reset_mid_op();
        test_random_w8c8();
        test_random_w16c1();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/chunked_adder.md
# chunked_adder

Parametrised multi-cycle adder: adds two WIDTH-bit operands plus carry-in by processing CHUNK bits per clock through a registered carry. It trades latency for a short critical path. Operands enter and results leave through valid/ready handshakes, so the block can sit between pipeline stages of the datapath. It produces sum, carry-out and two's-complement overflow.

## Interface
Parameters:
- WIDTH, default 32: operand and sum width.
- CHUNK, default 4: bits added per cycle. WIDTH % CHUNK == 0 and CHUNK >= 1; elaboration error otherwise. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operand set offered.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- s  out  WIDTH  sum, a + b + cin mod 2^WIDTH.
- cout  out  1  unsigned carry-out.
- ovf  out  1  signed overflow, defined as carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, BUSY, DONE.
- Outputs are fully registered except in_ready.
- in_ready = (state == IDLE).
- **IDLE**
  - On in_valid && in_ready, capture a, b and cin into operand shift registers and the carry register.
  - Clear chunk index and sum register; go to BUSY.
  - in_valid is ignored in every other state.
- **BUSY**, each cycle:
  - Add the low CHUNK bits of the A/B shift registers and the carry register.
  - Shift the CHUNK-bit result into the sum register from the top; shift the operand registers right by CHUNK.
  - Store the chunk carry-out into the carry register; idx++.
  - On the cycle with idx == NCHUNK-1, also latch cout and ovf, using the final chunk's carry into its MSB.
  - Go to DONE.
- **DONE**
  - out_valid = 1; s, cout and ovf are held stable.
  - On out_ready, go to IDLE; out_valid drops the next cycle.
  - s, cout and ovf keep their last values until the next result.
- **Arithmetic**: unsigned modular. The carry chain is exact across chunk boundaries. CHUNK == WIDTH degenerates to a single BUSY cycle.
- **Reset**:
  - State IDLE; out_valid = 0, s = 0, cout = 0, ovf = 0; carry and index registers 0.
  - in_ready = 1 in the first cycle after reset.
- **Reset mid-operation** (BUSY or DONE): the operation is aborted and the result discarded; no out_valid pulse.
- **Simultaneous events**: reset dominates in_valid and out_ready.

## Timing
- Operands accepted at edge T0, so BUSY occupies cycles T0..T0+NCHUNK-1.
- out_valid = 1 from edge T0+NCHUNK. Latency is NCHUNK cycles.
- Result consumed at the first edge with out_valid && out_ready.
- IDLE and in_ready = 1 resume at the following cycle.
- Minimum issue interval is NCHUNK+2 cycles with out_ready held high.
- Backpressure: with out_ready low, DONE is held indefinitely with outputs stable and in_ready = 0.
- Critical path: one CHUNK-bit ripple plus the carry register.

## Structure
- adder_pkg holds:
  - typedef enum logic [1:0] {IDLE, BUSY, DONE} adder_state_t.
  - a function computing NCHUNK with the divisibility check.
- Sub-module chunk_adder #(CHUNK):
  - Combinational ripple of CHUNK fulladder instances.
  - Inputs: a, b, cin. Outputs: s, cout, c_msb, where c_msb is the carry into the top bit.
- chunked_adder holds the FSM, shift registers, carry/index registers and output registers.

## Test plan
Unless noted, WIDTH=8, CHUNK=2 (NCHUNK=4).
1. Reset for 2 cycles, then release -> s=0x00, cout=0, ovf=0, out_valid=0, in_ready=1.
2. a=0x3C, b=0x05, cin=0 -> s=0x41, cout=0, ovf=0; out_valid first high exactly 4 cycles after the accept edge.
3. Carry ripple and overflow:
   - a=0xFF, b=0x01, cin=0 -> s=0x00, cout=1, ovf=0 (carry crosses all chunks).
   - a=0x7F, b=0x01 -> s=0x80, cout=0, ovf=1.
   - a=0x80, b=0x80 -> s=0x00, cout=1, ovf=1.
4. Result pending, out_ready low for 5 cycles, in_valid high with new operands -> in_ready=0, outputs unchanged, new operands ignored. Then raise out_ready -> handshake, next in_ready=1, new operation accepted.
5. Reset asserted in the 2nd BUSY cycle -> IDLE next cycle, no out_valid. Then a=0x12, b=0x34, cin=1 -> s=0x47, cout=0, ovf=0.
6. Instance with WIDTH=8, CHUNK=8 and instance with WIDTH=16, CHUNK=1; random a/b/cin vs reference model, 1000 operations each:
   - All results match.
   - Latencies are 1 and 16 respectively.
   - Issue interval with out_ready held high is NCHUNK+2.
